ca_pixel_engine: RTL and testbench
==================================

// Module: ca_pixel_engine
// PURPOSE
//  Streaming 3x3 chromatic-adaptation core; next-generation pixel datapath for the CCT->Bradford chain.
//  Applies a double-buffered signed fixed-point matrix to parametrised-width RGB beats with valid/ready flow control.
//  A new matrix is staged in a shadow bank and swapped in only at a frame boundary, so no frame is ever split between two matrices.
//  Sits between the pixel source and display_driver; the matrix source writes it through a coefficient port.
// PARAMETERS
//  PIX_W      8   bits per colour channel, unsigned
//  COEF_W     18  coefficient width, signed two's complement
//  FRAC_BITS  14  fractional bits of each coefficient; 1.0 = 1<<FRAC_BITS
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  coef_wr      in   1          write coef_data into shadow[coef_addr]
//  coef_addr    in   4          0..8, row-major: m00,m01,m02,m10..m22
//  coef_data    in   COEF_W     signed coefficient
//  coef_commit  in   1          mark the shadow bank pending for swap
//  bypass       in   1          pass pixels unmodified; sampled per beat
//  s_data       in   3*PIX_W    input pixel {R,G,B}, R in the MSBs
//  s_valid      in   1          input beat valid
//  s_ready      out  1          input beat accepted when s_valid & s_ready
//  s_sof        in   1          first beat of a frame
//  s_eof        in   1          last beat of a frame
//  m_data       out  3*PIX_W    output pixel {R,G,B}
//  m_valid      out  1          output beat valid
//  m_ready      in   1          downstream accepts the beat
//  m_sof        out  1          sof delayed with its beat
//  m_eof        out  1          eof delayed with its beat
//  matrix_pending out 1         committed shadow is waiting for the next sof
//  coef_err     out  1          1-cycle pulse on an illegal coefficient write
//  sat_count    out  16         clamped beats in the last completed frame
// BEHAVIOUR
//  Reset: all outputs 0 except s_ready=1; both banks = identity (diagonal 1<<FRAC_BITS, others 0); pipeline empty.
//  Pipeline: 3 stages (S1 register beat + active matrix + bypass; S2 nine products; S3 sum/round/clamp).
//  Stall: the single enable en = ~m_valid | m_ready advances all stages together; s_ready = en.
//  Latency: exactly 3 cycles from an accepted beat to m_valid with no stall; throughput 1 beat/cycle.
//  m_data, m_sof and m_eof hold stable while m_valid & ~m_ready. Bubbles propagate as valid=0.
//  Arithmetic, per output channel i:
//   acc = sum_j m_ij * {1'b0, c_j}, signed, width PIX_W+COEF_W+3.
//   Add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
//   Clamp to [0, 2^PIX_W-1]. A beat counts as saturated if any channel clamps.
//  Bypass beat: m_data = s_data. Bypass beats never count as saturated.
//  Coefficient bank:
//   coef_wr with addr<=8 and matrix_pending=0 writes shadow.
//   coef_wr with addr>8, or while matrix_pending=1, is dropped and coef_err pulses 1 cycle.
//   coef_commit sets matrix_pending. A commit while already pending is a no-op.
//  Swap: on an accepted beat with s_sof=1 while matrix_pending=1, active<=shadow in the same cycle.
//   That beat and all later beats use the new matrix; matrix_pending clears.
//  Commit and sof in the same cycle: the pending flag sets; the swap waits for the next sof.
//  coef_wr and coef_commit in the same cycle: the write lands first, then pending sets.
//  A beat in flight always keeps the matrix it captured in S1; a swap never alters beats already in S2/S3.
//  Reset mid-frame: pipeline flushed, banks back to identity, pending cleared; no partial beat emitted.
// CONFIGURATION
//  CA_SAT_COUNT_EN defined:
//   An internal 16-bit counter increments per saturated output beat and saturates at 16'hFFFF.
//   On the m_valid & m_ready beat with m_eof=1, the count including that beat is copied to sat_count and the counter clears.
//   A handshaken m_sof beat restarts the counter, so an eof-less frame is discarded.
//  CA_SAT_COUNT_EN undefined: sat_count tied to 16'h0; no counter logic.
// TESTING
//  Identity after reset, s_data=24'h3C80F0 with m_ready=1 -> m_data=24'h3C80F0, 3 cycles later.
//  Shadow = 2.0 diagonal (32768), commit mid-frame, 4 beats of 24'h404040 -> same frame unchanged; next sof beat and after = 24'h808080; matrix_pending falls at that sof.
//  Diagonal 1.5, input 24'hC80A00 -> 24'hFF0F00; with CA_SAT_COUNT_EN, 10-beat frame of this pixel -> sat_count=10 at eof.
//  Negative m01=-0.25 (-4096), others identity, input G=8'hFF, R=0 -> R out clamps to 0.
//  m_ready toggled 1-0-0-1 under a continuous 16-beat stream -> no loss or duplication; order kept; s_ready=0 during the stall.
//  coef_wr addr=9 and coef_wr while pending -> coef_err pulses, shadow unchanged. rst_n low mid-frame -> m_valid=0, identity restored.

Source files
------------

// File: rtl/ca_pixel_engine.sv
// Streaming 3x3 chromatic-adaptation core with a double-buffered coefficient bank.
// Optional feature macro: CA_SAT_COUNT_EN (per-frame saturated-beat counter).
module ca_pixel_engine #(
  parameter int PIX_W     = 8,
  parameter int COEF_W    = 18,
  parameter int FRAC_BITS = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coef_wr,
  input  logic [3:0]          coef_addr,
  input  logic [COEF_W-1:0]   coef_data,
  input  logic                coef_commit,
  input  logic                bypass,
  input  logic [3*PIX_W-1:0]  s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_sof,
  input  logic                s_eof,
  output logic [3*PIX_W-1:0]  m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_sof,
  output logic                m_eof,
  output logic                matrix_pending,
  output logic                coef_err,
  output logic [15:0]         sat_count
);
  localparam int PW = COEF_W + PIX_W + 1;
  localparam int AW = PIX_W + COEF_W + 3;
  localparam logic [COEF_W-1:0] ONE = COEF_W'(1) << FRAC_BITS;
  localparam logic signed [AW-1:0] RND = AW'(1) << (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] MAXV = (AW'(1) << PIX_W) - AW'(1);

  typedef logic [8:0][COEF_W-1:0] mat_t;

  function automatic mat_t ident();
    mat_t m;
    for (int k = 0; k < 9; k++)
      m[k] = (k % 4 == 0) ? ONE : '0;
    return m;
  endfunction

  localparam mat_t IDENT = ident();

  mat_t shadow_q, active_q, s1_m_q;
  logic pending_q, pending_d, coef_err_q;
  logic en, acc_s, swap, wr_ok;

  logic               s1_valid_q, s1_sof_q, s1_eof_q, s1_byp_q;
  logic [3*PIX_W-1:0] s1_data_q;
  logic               s2_valid_q, s2_sof_q, s2_eof_q, s2_byp_q;
  logic [3*PIX_W-1:0] s2_data_q;
  logic [8:0][PW-1:0] prod_d, prod_q;
  logic               m_valid_q, m_sof_q, m_eof_q, sat_q;
  logic [3*PIX_W-1:0] m_data_q;

  logic signed [AW-1:0] acc [3];
  logic signed [AW-1:0] shr [3];
  logic [3*PIX_W-1:0] pix_d, out_d;
  logic sat_d, osat;

  assign en      = ~m_valid_q | m_ready;
  assign s_ready = en;
  assign acc_s   = s_valid & en;
  assign swap    = acc_s & s_sof & pending_q;
  assign wr_ok   = coef_wr & (coef_addr <= 4'd8) & ~pending_q;
  // a commit landing while the swap fires is absorbed by that swap
  assign pending_d = swap ? 1'b0 : (pending_q | coef_commit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= IDENT;
      active_q   <= IDENT;
      pending_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 9; k++)
        if (wr_ok && coef_addr == 4'(k)) shadow_q[k] <= coef_data;
      if (swap) active_q <= shadow_q;
      pending_q  <= pending_d;
      coef_err_q <= coef_wr & ~wr_ok;
    end
  end

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        prod_d[3*i+j] = PW'($signed(s1_m_q[3*i+j]))
                      * PW'($signed({1'b0, s1_data_q[(2-j)*PIX_W +: PIX_W]}));
  end

  always_comb begin
    pix_d = '0;
    sat_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc[i] = AW'($signed(prod_q[3*i]))
             + AW'($signed(prod_q[3*i+1]))
             + AW'($signed(prod_q[3*i+2])) + RND;
      shr[i] = acc[i] >>> FRAC_BITS;
      if (shr[i][AW-1]) begin
        sat_d = 1'b1;
      end else if (shr[i] > MAXV) begin
        pix_d[(2-i)*PIX_W +: PIX_W] = '1;
        sat_d = 1'b1;
      end else begin
        pix_d[(2-i)*PIX_W +: PIX_W] = shr[i][PIX_W-1:0];
      end
    end
    out_d = s2_byp_q ? s2_data_q : pix_d;
    osat  = ~s2_byp_q & sat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_data_q  <= '0;
      s1_m_q     <= IDENT;
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_eof_q   <= 1'b0;
      s2_byp_q   <= 1'b0;
      s2_data_q  <= '0;
      prod_q     <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      m_data_q   <= '0;
      sat_q      <= 1'b0;
    end else if (en) begin
      s1_valid_q <= s_valid;
      s1_sof_q   <= s_sof;
      s1_eof_q   <= s_eof;
      s1_byp_q   <= bypass;
      s1_data_q  <= s_data;
      s1_m_q     <= swap ? shadow_q : active_q;
      s2_valid_q <= s1_valid_q;
      s2_sof_q   <= s1_sof_q;
      s2_eof_q   <= s1_eof_q;
      s2_byp_q   <= s1_byp_q;
      s2_data_q  <= s1_data_q;
      prod_q     <= prod_d;
      m_valid_q  <= s2_valid_q;
      m_sof_q    <= s2_sof_q;
      m_eof_q    <= s2_eof_q;
      m_data_q   <= out_d;
      sat_q      <= osat;
    end
  end

  assign m_data         = m_data_q;
  assign m_valid        = m_valid_q;
  assign m_sof          = m_sof_q;
  assign m_eof          = m_eof_q;
  assign matrix_pending = pending_q;
  assign coef_err       = coef_err_q;

`ifdef CA_SAT_COUNT_EN
  logic [15:0] cnt_q, sat_count_q, base, tot;

  always_comb begin
    base = m_sof_q ? 16'h0 : cnt_q;
    tot  = (sat_q && base != 16'hFFFF) ? base + 16'h1 : base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 16'h0;
      sat_count_q <= 16'h0;
    end else if (m_valid_q && m_ready) begin
      if (m_eof_q) begin
        sat_count_q <= tot;
        cnt_q       <= 16'h0;
      end else begin
        cnt_q <= tot;
      end
    end
  end

  assign sat_count = sat_count_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
  assign sat_count  = 16'h0;
`endif
endmodule

// File: tb/tb_ca_pixel_engine.sv
// Scoreboard bench for ca_pixel_engine.
// Honours CA_SAT_COUNT_EN for the sat_count expectation.
module tb_ca_pixel_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_wr = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [17:0] coef_data = '0;
  logic        coef_commit = 1'b0;
  logic        bypass = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_sof = 1'b0;
  logic        s_eof = 1'b0;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_sof, m_eof;
  logic        matrix_pending, coef_err;
  logic [15:0] sat_count;

  ca_pixel_engine dut (
    .clk(clk), .rst_n(rst_n),
    .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit),
    .bypass(bypass),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_sof(s_sof), .s_eof(s_eof),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eof(m_eof),
    .matrix_pending(matrix_pending), .coef_err(coef_err),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int act [9];
  int shd [9];
  bit pend;
  logic [26:0] q [$];
  int mcnt;
  int exp_sc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      act[k] = (k % 4 == 0) ? 16384 : 0;
      shd[k] = act[k];
    end
    pend = 1'b0;
  endtask

  function automatic logic [24:0] model(input logic [23:0] px);
    int c [3];
    int s;
    logic [23:0] o;
    logic st;
    c[0] = int'(px[23:16]);
    c[1] = int'(px[15:8]);
    c[2] = int'(px[7:0]);
    o = '0;
    st = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = 0;
      for (int j = 0; j < 3; j++) s += act[3*i+j] * c[j];
      s = (s + 8192) >>> 14;
      if (s < 0) begin
        s = 0;
        st = 1'b1;
      end else if (s > 255) begin
        s = 255;
        st = 1'b1;
      end
      o[(2-i)*8 +: 8] = 8'(s);
    end
    return {st, o};
  endfunction

  task automatic send(input logic [23:0] px, input logic sof,
                      input logic eof, input logic byp);
    logic ok;
    logic [24:0] r;
    int n;
    s_data = px;
    s_sof = sof;
    s_eof = eof;
    bypass = byp;
    s_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!ok) begin
      chk("send_timeout", 0, 1);
    end else begin
      if (sof && pend) begin
        act = shd;
        pend = 1'b0;
      end
      r = byp ? {1'b0, px} : model(px);
      q.push_back({r[24], sof, eof, r[23:0]});
    end
  endtask

  task automatic wcoef(input int a, input int d);
    bit e;
    e = (a > 8) || pend;
    if (!e) shd[a] = d;
    coef_wr = 1'b1;
    coef_addr = 4'(a);
    coef_data = 18'(d);
    @(posedge clk);
    #1;
    coef_wr = 1'b0;
    chk("coef_err", {31'b0, coef_err}, {31'b0, e});
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    @(posedge clk);
    #1;
    coef_commit = 1'b0;
    pend = 1'b1;
    chk("pending_set", {31'b0, matrix_pending}, 1);
  endtask

  task automatic wmat(input int d, input int m01);
    for (int k = 0; k < 9; k++)
      wcoef(k, (k % 4 == 0) ? d : ((k == 1) ? m01 : 0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin : monitor
    logic [26:0] e;
    int base, tot;
    mcnt = 0;
    exp_sc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcnt = 0;
        exp_sc = 0;
      end else begin
        if (m_valid && !m_ready)
          chk("s_ready_stall", {31'b0, s_ready}, 0);
        if (m_valid && m_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", {8'b0, m_data}, 32'hFFFFFFFF);
          end else begin
            e = q.pop_front();
            chk("m_data", {8'b0, m_data}, {8'b0, e[23:0]});
            chk("m_sof", {31'b0, m_sof}, {31'b0, e[25]});
            chk("m_eof", {31'b0, m_eof}, {31'b0, e[24]});
            base = m_sof ? 0 : mcnt;
            tot = (e[26] && base < 65535) ? base + 1 : base;
            if (m_eof) begin
              exp_sc = tot;
              mcnt = 0;
            end else begin
              mcnt = tot;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [3:0] pat;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {31'b0, s_ready}, 1);
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_m_data", {8'b0, m_data}, 0);
    chk("rst_pending", {31'b0, matrix_pending}, 0);
    chk("rst_coef_err", {31'b0, coef_err}, 0);
    chk("rst_sat_count", {16'b0, sat_count}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(24'h3C80F0, 1'b1, 1'b1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 10);
    chk("latency", n, 3);
    drain();

    wmat(32768, 0);
    send(24'h404040, 1'b1, 1'b0, 1'b0);
    send(24'h404040, 1'b0, 1'b0, 1'b0);
    commit();
    send(24'h404040, 1'b0, 1'b0, 1'b0);
    send(24'h404040, 1'b0, 1'b1, 1'b0);
    chk("pending_hold", {31'b0, matrix_pending}, 1);
    send(24'h404040, 1'b1, 1'b0, 1'b0);
    chk("pending_clr", {31'b0, matrix_pending}, 0);
    send(24'h404040, 1'b0, 1'b1, 1'b0);
    drain();

    wmat(24576, 0);
    commit();
    for (int i = 0; i < 10; i++)
      send(24'hC80A00, i == 0, i == 9, 1'b0);
    drain();
`ifdef CA_SAT_COUNT_EN
    chk("sat_count_model", exp_sc, 10);
    chk("sat_count", {16'b0, sat_count}, exp_sc);
`else
    chk("sat_count", {16'b0, sat_count}, 0);
`endif

    wmat(16384, -4096);
    commit();
    send(24'h00FF00, 1'b1, 1'b0, 1'b0);
    send(24'h80FF00, 1'b0, 1'b1, 1'b0);
    drain();

    pat = 4'b1001;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(24'($urandom), i == 0 || i == 8, i == 7 || i == 15, i % 5 == 2);
      end
      begin
        for (int k = 0; k < 48; k++) begin
          m_ready = pat[k % 4];
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    drain();

    wcoef(9, 0);
    @(posedge clk);
    #1;
    chk("coef_err_pulse", {31'b0, coef_err}, 0);
    wcoef(0, 32768);
    commit();
    wcoef(4, 0);
    send(24'h101010, 1'b1, 1'b0, 1'b0);
    send(24'h80FF00, 1'b0, 1'b1, 1'b0);
    drain();

    wcoef(0, 49152);
    commit();
    send(24'h80FF00, 1'b0, 1'b0, 1'b0);
    send(24'h80FF00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", {31'b0, m_valid}, 0);
    chk("midrst_pending", {31'b0, matrix_pending}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(24'h80FF00, 1'b1, 1'b0, 1'b0);
    send(24'h3C80F0, 1'b0, 1'b1, 1'b0);
    drain();
    chk("post_rst_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
